// File: rtl/pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage,
// carry registered between stages, valid/ready handshake with whole-pipe stall.
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int STAGES = WIDTH / SEG_W;

    generate
        if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_width
            $error("pipe_addsub: WIDTH must be a non-zero multiple of SEG_W");
        end
    endgenerate

    // Kogge-Stone prefix over one segment; returns {cout, carry into MSB, sum}.
    function automatic logic [SEG_W+1:0] cla_seg(
        input logic [SEG_W-1:0] a,
        input logic [SEG_W-1:0] b,
        input logic             ci
    );
        logic [SEG_W-1:0] p, g, gp, pp, gn, pn;
        logic [SEG_W:0]   c;
        p  = a ^ b;
        g  = a & b;
        gp = g;
        pp = p;
        for (int unsigned d = 1; d < SEG_W; d = d * 2) begin
            gn = gp;
            pn = pp;
            for (int unsigned i = d; i < SEG_W; i++) begin
                gn[i] = gp[i] | (pp[i] & gp[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            gp = gn;
            pp = pn;
        end
        c[0] = ci;
        for (int unsigned i = 0; i < SEG_W; i++) begin
            c[i+1] = gp[i] | (pp[i] & ci);
        end
        return {c[SEG_W], c[SEG_W-1], p ^ c[SEG_W-1:0]};
    endfunction

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              adv;

    logic [WIDTH-1:0]  a_in, b_in, s_in;
    logic              c_in, v_in;
    logic [SEG_W+1:0]  seg;

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = rst_n && adv;

    // Operands travel whole with each op; stage k only consumes segment k of them.
    always_comb begin
        v_d    = '0;
        c_d    = '0;
        ovf_d  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        s_in   = '0;
        c_in   = 1'b0;
        v_in   = 1'b0;
        seg    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                a_in = in_a;
                b_in = in_sub ? ~in_b : in_b;
                s_in = '0;
                c_in = in_sub ? 1'b1 : in_cin;
                v_in = in_valid;
            end else begin
                a_in = a_q[k-1];
                b_in = b_q[k-1];
                s_in = s_q[k-1];
                c_in = c_q[k-1];
                v_in = v_q[k-1];
            end
            seg    = cla_seg(a_in[k*SEG_W +: SEG_W], b_in[k*SEG_W +: SEG_W], c_in);
            a_d[k] = a_in;
            b_d[k] = b_in;
            s_d[k] = s_in;
            s_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            c_d[k] = seg[SEG_W+1];
            v_d[k] = v_in;
            if (k == STAGES - 1) begin
                ovf_d = seg[SEG_W+1] ^ seg[SEG_W];
            end
        end
        zero_d = (s_d[STAGES-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
        end
    end

endmodule
